// File: rtl/flash_bridge.sv
// flash_bridge: Wishbone-style bus to 16-bit Intel-command-set NOR flash bridge.
// Performs halfword or two-halfword reads, and program/erase with status polling and timeout.
module flash_bridge #(
    parameter int ADDR_W        = 22,
    parameter int ACCESS_CYCLES = 4,
    parameter int WORD_READ     = 1,
    parameter int POLL_MAX      = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       bus_addr_i,
    input  logic [31:0]       bus_data_i,
    output logic [31:0]       bus_data_o,
    input  logic              bus_select_i,
    input  logic              bus_we_i,
    output logic              bus_ack_o,
    output logic [ADDR_W-1:0] flash_addr,
    inout  wire  [15:0]       flash_data,
    output logic              flash_ce_n,
    output logic              flash_oe_n,
    output logic              flash_we_n,
    output logic              flash_rp_n,
    output logic              flash_byte_n
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, CMD1, CMD2, POLL, RESTORE, ACK
    } state_t;

    localparam logic [3:0]  STROBE_LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0]  PHASE_LAST  = 4'(ACCESS_CYCLES);
    localparam logic [16:0] POLL_LIMIT  = 17'(POLL_MAX);

    state_t            state;
    state_t            next_state;
    logic [3:0]        phase_cnt;
    logic              phase_done;
    logic              sample_now;
    logic              capture;
    logic [15:0]       poll_cnt;
    logic              poll_exhausted;
    logic              poll_error;
    logic              req_we;
    logic              req_erase;
    logic [15:0]       req_data;
    logic [15:0]       rd_lo;
    logic [15:0]       rd_hi;
    logic [15:0]       status;
    logic              is_read;
    logic              is_write;
    logic              strobe_on;
    logic [15:0]       wdata;
    logic [ADDR_W-1:0] read_base;
    logic [ADDR_W-1:0] write_base;
    logic              unused_bits;

    assign capture        = (state == IDLE) && bus_select_i;
    assign phase_done     = (phase_cnt == PHASE_LAST);
    assign sample_now     = (phase_cnt == STROBE_LAST);
    assign poll_exhausted = ({1'b0, poll_cnt} + 17'd1) >= POLL_LIMIT;
    assign write_base     = bus_addr_i[ADDR_W:1];
    assign read_base      = (WORD_READ != 0) ? {bus_addr_i[ADDR_W:2], 1'b0} : bus_addr_i[ADDR_W:1];
    assign unused_bits    = ^{bus_addr_i[30:ADDR_W+1], bus_addr_i[0], bus_data_i[31:16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every non-IDLE/ACK state is exactly one phase: strobe cycles then one recovery cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus_select_i) begin
                    next_state = bus_we_i ? CMD1 : RD_LO;
                end
            end
            RD_LO: begin
                if (phase_done) begin
                    next_state = (WORD_READ != 0) ? RD_HI : ACK;
                end
            end
            RD_HI: begin
                if (phase_done) begin
                    next_state = ACK;
                end
            end
            CMD1: begin
                if (phase_done) begin
                    next_state = CMD2;
                end
            end
            CMD2: begin
                if (phase_done) begin
                    next_state = POLL;
                end
            end
            POLL: begin
                if (phase_done && (status[7] || poll_exhausted)) begin
                    next_state = RESTORE;
                end
            end
            RESTORE: begin
                if (phase_done) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        is_read   = 1'b0;
        is_write  = 1'b0;
        wdata     = 16'h0000;
        bus_ack_o = 1'b0;
        case (state)
            RD_LO, RD_HI, POLL: begin
                is_read = 1'b1;
            end
            CMD1: begin
                is_write = 1'b1;
                wdata    = req_erase ? 16'h0020 : 16'h0040;
            end
            CMD2: begin
                is_write = 1'b1;
                wdata    = req_erase ? 16'h00D0 : req_data;
            end
            RESTORE: begin
                is_write = 1'b1;
                wdata    = 16'h00FF;
            end
            ACK: begin
                bus_ack_o = 1'b1;
            end
            default: begin
                bus_ack_o = 1'b0;
            end
        endcase
        strobe_on  = (is_read || is_write) && (phase_cnt < PHASE_LAST);
        flash_ce_n = !strobe_on;
        flash_oe_n = !(strobe_on && is_read);
        flash_we_n = !(strobe_on && is_write);
    end

    // Write data stays on the bus through the recovery cycle for hold time.
    assign flash_data   = is_write ? wdata : 16'hzzzz;
    assign flash_byte_n = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt  <= '0;
            flash_rp_n <= 1'b0;
        end else begin
            flash_rp_n <= 1'b1;
            if (state == IDLE || state == ACK || phase_done) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we     <= 1'b0;
            req_erase  <= 1'b0;
            req_data   <= '0;
            flash_addr <= '0;
            poll_cnt   <= '0;
            poll_error <= 1'b0;
        end else begin
            if (capture) begin
                req_we     <= bus_we_i;
                req_erase  <= bus_addr_i[31];
                req_data   <= bus_data_i[15:0];
                flash_addr <= bus_we_i ? write_base : read_base;
                poll_cnt   <= '0;
                poll_error <= 1'b0;
            end
            // Move to the upper halfword in the recovery cycle, after the low half is sampled.
            if ((WORD_READ != 0) && state == RD_LO && sample_now) begin
                flash_addr[0] <= 1'b1;
            end
            if (state == POLL && phase_done) begin
                poll_cnt <= poll_cnt + 16'd1;
                if (!status[7] && poll_exhausted) begin
                    poll_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_lo  <= '0;
            rd_hi  <= '0;
            status <= '0;
        end else if (sample_now) begin
            case (state)
                RD_LO:   rd_lo  <= flash_data;
                RD_HI:   rd_hi  <= flash_data;
                POLL:    status <= flash_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_data_o <= '0;
        end else if (state != ACK && next_state == ACK) begin
            if (req_we) begin
                bus_data_o <= {poll_error, 15'h0000, status};
            end else begin
                bus_data_o <= {((WORD_READ != 0) ? rd_hi : 16'h0000), rd_lo};
            end
        end
    end

endmodule

// File: tb/tb_flash_bridge.sv
// tb_flash_bridge: directed bench for flash_bridge with a behavioural flash model.
// Two bridges share the bus inputs: a halfword/short-timeout one and a word-read one.
module tb_flash_bridge;

    localparam int AW = 22;
    localparam int A  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_wdata;
    logic             bus_we;
    logic [1:0]       sel;
    logic [1:0][31:0] rdata;
    logic [1:0]       ack, ce_n, oe_n, we_n, rp_n, byte_n;
    logic [1:0][AW-1:0] faddr;
    wire  [15:0]      fd0, fd1;
    logic [15:0]      drv0, drv1;
    logic [1:0]       in_status;
    int               polls_seen [2];
    int               ready_after [2];
    logic             probe;

    int               checks;
    int               fails;
    int               op_latency, op_oe_cycles, op_nwr, op_npoll, op_nrd, op_unstable;
    logic [31:0]      op_rdata;
    logic [15:0]      wr_data [4];
    logic [AW-1:0]    wr_addr [4];
    logic [AW-1:0]    rd_addr [4];

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [AW-1:0] a);
        case (a)
            22'd8:   return 16'hBEEF;
            22'd4:   return 16'h1234;
            22'd5:   return 16'hABCD;
            default: return {4'h6, a[11:0]};
        endcase
    endfunction

    assign drv0 = in_status[0] ? ((polls_seen[0] >= ready_after[0]) ? 16'h0080 : 16'h0000) : mem_val(faddr[0]);
    assign drv1 = in_status[1] ? ((polls_seen[1] >= ready_after[1]) ? 16'h0080 : 16'h0000) : mem_val(faddr[1]);
    assign fd0  = !oe_n[0] ? drv0 : 16'hzzzz;
    assign fd1  = !oe_n[1] ? drv1 : 16'hzzzz;
    assign fd1  = probe ? 16'hC33C : 16'hzzzz;

    flash_bridge #(.ADDR_W(AW), .ACCESS_CYCLES(A), .WORD_READ(0), .POLL_MAX(3)) dut_half (
        .clk(clk), .rst(rst), .bus_addr_i(bus_addr), .bus_data_i(bus_wdata), .bus_data_o(rdata[0]),
        .bus_select_i(sel[0]), .bus_we_i(bus_we), .bus_ack_o(ack[0]), .flash_addr(faddr[0]),
        .flash_data(fd0), .flash_ce_n(ce_n[0]), .flash_oe_n(oe_n[0]), .flash_we_n(we_n[0]),
        .flash_rp_n(rp_n[0]), .flash_byte_n(byte_n[0])
    );

    flash_bridge #(.ADDR_W(AW), .ACCESS_CYCLES(A), .WORD_READ(1), .POLL_MAX(65535)) dut_word (
        .clk(clk), .rst(rst), .bus_addr_i(bus_addr), .bus_data_i(bus_wdata), .bus_data_o(rdata[1]),
        .bus_select_i(sel[1]), .bus_we_i(bus_we), .bus_ack_o(ack[1]), .flash_addr(faddr[1]),
        .flash_data(fd1), .flash_ce_n(ce_n[1]), .flash_oe_n(oe_n[1]), .flash_we_n(we_n[1]),
        .flash_rp_n(rp_n[1]), .flash_byte_n(byte_n[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        in_status     = 2'b00;
        polls_seen[0] = 0;
        polls_seen[1] = 0;
    endtask

    // Issues one request to bridge u and follows it to its ack, logging flash-side activity.
    task automatic applyStimulus(input int u, input logic [31:0] addr, input logic [31:0] data,
                                 input logic we, input int sel_cycles);
        logic          prev_ce, prev_oe, prev_we;
        logic [AW-1:0] prev_addr;
        logic [15:0]   prev_fd, cur_fd;
        int            cycles;
        bit            done;
        bus_addr  = addr;
        bus_wdata = data;
        bus_we    = we;
        sel[u]    = 1'b1;
        op_latency = 0; op_rdata = '0; op_oe_cycles = 0; op_nwr = 0;
        op_npoll = 0; op_nrd = 0; op_unstable = 0;
        prev_ce = 1'b1; prev_oe = 1'b1; prev_we = 1'b1; prev_addr = '0; prev_fd = '0;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 400) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (cycles == sel_cycles) begin
                sel[u]    = 1'b0;
                bus_addr  = 32'h7FFF_FFFE;
                bus_wdata = 32'hFFFF_1111;
                bus_we    = ~we;
            end
            cur_fd = (u == 0) ? fd0 : fd1;
            if (!ce_n[u] && !prev_ce && faddr[u] != prev_addr) op_unstable++;
            if (!we_n[u] && !prev_we && cur_fd != prev_fd) op_unstable++;
            if (!oe_n[u]) op_oe_cycles++;
            if (!oe_n[u] && prev_oe) begin
                if (op_nrd < 4) rd_addr[op_nrd] = faddr[u];
                op_nrd++;
                if (in_status[u]) begin
                    polls_seen[u]++;
                    op_npoll++;
                end
            end
            if (!we_n[u] && prev_we) begin
                if (op_nwr < 4) begin
                    wr_data[op_nwr] = cur_fd;
                    wr_addr[op_nwr] = faddr[u];
                end
                op_nwr++;
                in_status[u] = (cur_fd != 16'h00FF);
            end
            prev_ce = ce_n[u]; prev_oe = oe_n[u]; prev_we = we_n[u];
            prev_addr = faddr[u]; prev_fd = cur_fd;
            if (ack[u]) begin
                done       = 1'b1;
                op_latency = cycles;
                op_rdata   = rdata[u];
            end
        end
        if (!done) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
        end else if (sel_cycles < 100) begin
            @(negedge clk);
            checkOutput("ack_single_cycle", {31'd0, ack[u]}, 32'd0);
        end
    endtask

    // Starts an operation on the word bridge and asserts rst part-way through it.
    task automatic resetMidOp(input logic [31:0] addr, input logic we, input int cycles_in);
        bus_addr  = addr;
        bus_wdata = 32'h0000_1357;
        bus_we    = we;
        sel[1]    = 1'b1;
        repeat (cycles_in) begin
            @(posedge clk);
            @(negedge clk);
            sel[1] = 1'b0;
        end
        checkOutput("midop_strobe_active", {31'd0, ce_n[1]}, 32'd0);
        rst   = 1'b1;
        probe = 1'b1;
        #1;
        checkOutput("midop_rst_strobes", {29'd0, ce_n[1], oe_n[1], we_n[1]}, 32'd7);
        checkOutput("midop_rst_ack", {31'd0, ack[1]}, 32'd0);
        checkOutput("midop_rst_rp", {31'd0, rp_n[1]}, 32'd0);
        checkOutput("midop_rst_rdata", rdata[1], 32'd0);
        checkOutput("midop_rst_addr", {10'd0, faddr[1]}, 32'd0);
        checkOutput("midop_rst_data_released", {16'd0, fd1}, 32'h0000_C33C);
        @(negedge clk);
        probe = 1'b0;
        rst   = 1'b0;
        checkOutput("rp_low_until_edge", {31'd0, rp_n[1]}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rp_high_after_edge", {31'd0, rp_n[1]}, 32'd1);
        @(negedge clk);
        resetModel();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        sel    = 2'b00;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        probe     = 1'b0;
        ready_after[0] = 1000;
        ready_after[1] = 1000;
        resetModel();
        repeat (3) @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            checkOutput("reset_strobes", {29'd0, ce_n[u], oe_n[u], we_n[u]}, 32'd7);
            checkOutput("reset_ack", {31'd0, ack[u]}, 32'd0);
            checkOutput("reset_rp", {31'd0, rp_n[u]}, 32'd0);
            checkOutput("reset_rdata", rdata[u], 32'd0);
            checkOutput("reset_addr", {10'd0, faddr[u]}, 32'd0);
            checkOutput("byte_mode", {31'd0, byte_n[u]}, 32'd1);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rp_release", {30'd0, rp_n}, 32'd3);

        $display("[TB] halfword reads");
        applyStimulus(0, 32'h0000_0010, 32'h0, 1'b0, 1);
        checkOutput("hw_latency", op_latency, 32'd6);
        checkOutput("hw_rdata", op_rdata, 32'h0000_BEEF);
        checkOutput("hw_oe_cycles", op_oe_cycles, 32'd4);
        checkOutput("hw_addr", {10'd0, rd_addr[0]}, 32'd8);
        checkOutput("hw_nreads", op_nrd, 32'd1);
        checkOutput("hw_stable", op_unstable, 32'd0);
        applyStimulus(0, 32'h0000_0012, 32'h0, 1'b0, 1);
        checkOutput("hw_odd_rdata", op_rdata, 32'h0000_6009);
        checkOutput("hw_odd_addr", {10'd0, rd_addr[0]}, 32'd9);

        $display("[TB] word reads");
        applyStimulus(1, 32'h0000_0008, 32'h0, 1'b0, 1);
        checkOutput("wd_latency", op_latency, 32'd11);
        checkOutput("wd_rdata", op_rdata, 32'hABCD_1234);
        checkOutput("wd_addr_lo", {10'd0, rd_addr[0]}, 32'd4);
        checkOutput("wd_addr_hi", {10'd0, rd_addr[1]}, 32'd5);
        checkOutput("wd_oe_cycles", op_oe_cycles, 32'd8);
        checkOutput("wd_stable", op_unstable, 32'd0);
        applyStimulus(1, 32'h0000_000A, 32'h0, 1'b0, 1);
        checkOutput("wd_unaligned_rdata", op_rdata, 32'hABCD_1234);

        $display("[TB] program");
        resetModel();
        ready_after[1] = 3;
        applyStimulus(1, 32'h0000_0020, 32'hDEAD_5A5A, 1'b1, 1);
        checkOutput("pg_latency", op_latency, 32'd31);
        checkOutput("pg_status", op_rdata, 32'h0000_0080);
        checkOutput("pg_nwrites", op_nwr, 32'd3);
        checkOutput("pg_cmd1", {16'd0, wr_data[0]}, 32'h0040);
        checkOutput("pg_cmd2", {16'd0, wr_data[1]}, 32'h5A5A);
        checkOutput("pg_restore", {16'd0, wr_data[2]}, 32'h00FF);
        checkOutput("pg_addr_cmd1", {10'd0, wr_addr[0]}, 32'h10);
        checkOutput("pg_addr_cmd2", {10'd0, wr_addr[1]}, 32'h10);
        checkOutput("pg_polls", op_npoll, 32'd3);
        checkOutput("pg_stable", op_unstable, 32'd0);

        $display("[TB] erase");
        resetModel();
        ready_after[1] = 1;
        applyStimulus(1, 32'h8000_0000, 32'h0, 1'b1, 1);
        checkOutput("er_latency", op_latency, 32'd21);
        checkOutput("er_status", op_rdata, 32'h0000_0080);
        checkOutput("er_cmd1", {16'd0, wr_data[0]}, 32'h0020);
        checkOutput("er_cmd2", {16'd0, wr_data[1]}, 32'h00D0);
        checkOutput("er_restore", {16'd0, wr_data[2]}, 32'h00FF);
        checkOutput("er_addr", {10'd0, wr_addr[1]}, 32'h0);
        checkOutput("er_polls", op_npoll, 32'd1);

        $display("[TB] erase timeout");
        resetModel();
        ready_after[0] = 1000;
        applyStimulus(0, 32'h8000_0040, 32'h0, 1'b1, 1);
        checkOutput("to_polls", op_npoll, 32'd3);
        checkOutput("to_status", op_rdata, 32'h8000_0000);
        checkOutput("to_latency", op_latency, 32'd31);
        checkOutput("to_nwrites", op_nwr, 32'd3);
        checkOutput("to_restore", {16'd0, wr_data[2]}, 32'h00FF);
        checkOutput("to_addr", {10'd0, wr_addr[0]}, 32'h20);
        repeat (3) @(negedge clk);
        checkOutput("to_rdata_held", rdata[0], 32'h8000_0000);

        $display("[TB] back-to-back reads");
        resetModel();
        applyStimulus(1, 32'h0000_0008, 32'h0, 1'b0, 1000);
        checkOutput("b2b_first_rdata", op_rdata, 32'hABCD_1234);
        applyStimulus(1, 32'h0000_000C, 32'h0, 1'b0, 2);
        checkOutput("b2b_second_latency", op_latency, 32'd12);
        checkOutput("b2b_second_rdata", op_rdata, 32'h6007_6006);

        $display("[TB] reset mid-operation");
        resetMidOp(32'h0000_0008, 1'b0, 3);
        resetMidOp(32'h0000_0020, 1'b1, 7);
        applyStimulus(1, 32'h0000_0008, 32'h0, 1'b0, 1);
        checkOutput("post_rst_latency", op_latency, 32'd11);
        checkOutput("post_rst_rdata", op_rdata, 32'hABCD_1234);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
